// File: rtl/rename.sv
// ============================================================================
// Module   : rename
// Purpose  : Two-wide register rename with a register alias table and a
//            round-robin physical-register allocator over the upper pool.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rename #(
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [6:0]                   opcode_a,
   input  logic [$clog2(ARCH_REGS)-1:0] rd_a_arch,
   input  logic [$clog2(ARCH_REGS)-1:0] rs1_a_arch,
   input  logic [$clog2(ARCH_REGS)-1:0] rs2_a_arch,
   input  logic [6:0]                   opcode_b,
   input  logic [$clog2(ARCH_REGS)-1:0] rd_b_arch,
   input  logic [$clog2(ARCH_REGS)-1:0] rs1_b_arch,
   input  logic [$clog2(ARCH_REGS)-1:0] rs2_b_arch,
   output logic [$clog2(PHYS_REGS)-1:0] rd_a_phy,
   output logic [$clog2(PHYS_REGS)-1:0] rs1_a_phy,
   output logic [$clog2(PHYS_REGS)-1:0] rs2_a_phy,
   output logic [$clog2(PHYS_REGS)-1:0] rd_b_phy,
   output logic [$clog2(PHYS_REGS)-1:0] rs1_b_phy,
   output logic [$clog2(PHYS_REGS)-1:0] rs2_b_phy
);

   localparam int c_AW = $clog2(ARCH_REGS);
   localparam int c_PW = $clog2(PHYS_REGS);

   // Free pool spans the physical registers above the identity-mapped block.
   localparam logic [c_PW-1:0] c_POOL_BASE = c_PW'(ARCH_REGS);
   localparam logic [c_PW-1:0] c_POOL_LAST = c_PW'(PHYS_REGS - 1);

   logic [c_PW-1:0] r_rat [ARCH_REGS];
   logic [c_PW-1:0] r_alloc_ptr;

   logic            w_a_wr;
   logic            w_b_wr;
   logic [c_PW-1:0] w_ptr_plus1;
   logic [c_PW-1:0] w_b_alloc;
   logic [c_PW-1:0] w_ptr_next;

   function automatic logic writes_rd(input logic [6:0] op, input logic [c_AW-1:0] rd);
      logic w_op_wr;
      case (op)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: w_op_wr = 1'b1;
         default:                            w_op_wr = 1'b0;
      endcase
      return w_op_wr && (rd != '0);
   endfunction

   function automatic logic [c_PW-1:0] inc_ptr(input logic [c_PW-1:0] p);
      return (p == c_POOL_LAST) ? c_POOL_BASE : p + c_PW'(1);
   endfunction

   always_comb begin
      w_a_wr      = writes_rd(opcode_a, rd_a_arch);
      w_b_wr      = writes_rd(opcode_b, rd_b_arch);
      w_ptr_plus1 = inc_ptr(r_alloc_ptr);
      w_b_alloc   = w_a_wr ? w_ptr_plus1 : r_alloc_ptr;

      if (w_b_wr) begin
         w_ptr_next = inc_ptr(w_b_alloc);
      end else if (w_a_wr) begin
         w_ptr_next = w_ptr_plus1;
      end else begin
         w_ptr_next = r_alloc_ptr;
      end
   end

   always_comb begin
      rd_a_phy  = w_a_wr ? r_alloc_ptr : '0;
      rd_b_phy  = w_b_wr ? w_b_alloc : '0;
      rs1_a_phy = r_rat[rs1_a_arch];
      rs2_a_phy = r_rat[rs2_a_arch];
      // B sees A's fresh destination; rd_a_arch is nonzero whenever w_a_wr is set.
      rs1_b_phy = (w_a_wr && (rs1_b_arch == rd_a_arch)) ? r_alloc_ptr : r_rat[rs1_b_arch];
      rs2_b_phy = (w_a_wr && (rs2_b_arch == rd_a_arch)) ? r_alloc_ptr : r_rat[rs2_b_arch];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_rat[i] <= c_PW'(i);
         end
         r_alloc_ptr <= c_POOL_BASE;
      end else begin
         if (w_a_wr) begin
            r_rat[rd_a_arch] <= r_alloc_ptr;
         end
         // Later assignment lets B win when both slots target the same register.
         if (w_b_wr) begin
            r_rat[rd_b_arch] <= w_b_alloc;
         end
         r_alloc_ptr <= w_ptr_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rename.sv
// ============================================================================
// Module   : tb_rename
// Purpose  : Directed self-checking bench for the two-wide rename stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rename;

   localparam logic [6:0] c_OP     = 7'b0110011;
   localparam logic [6:0] c_OPIMM  = 7'b0010011;
   localparam logic [6:0] c_LOAD   = 7'b0000011;
   localparam logic [6:0] c_LUI    = 7'b0110111;
   localparam logic [6:0] c_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_JAL    = 7'b1101111;
   localparam logic [6:0] c_JALR   = 7'b1100111;
   localparam logic [6:0] c_STORE  = 7'b0100011;
   localparam logic [6:0] c_BRANCH = 7'b1100011;
   localparam logic [6:0] c_SYSTEM = 7'b1110011;

   logic       clk;
   logic       reset;
   logic [6:0] opcode_a, opcode_b;
   logic [4:0] rd_a_arch, rs1_a_arch, rs2_a_arch;
   logic [4:0] rd_b_arch, rs1_b_arch, rs2_b_arch;
   logic [5:0] rd_a_phy, rs1_a_phy, rs2_a_phy;
   logic [5:0] rd_b_phy, rs1_b_phy, rs2_b_phy;

   int checks = 0;
   int errors = 0;

   logic [6:0] wr_ops [7];

   rename dut (
      .clk        (clk),
      .reset      (reset),
      .opcode_a   (opcode_a),
      .rd_a_arch  (rd_a_arch),
      .rs1_a_arch (rs1_a_arch),
      .rs2_a_arch (rs2_a_arch),
      .opcode_b   (opcode_b),
      .rd_b_arch  (rd_b_arch),
      .rs1_b_arch (rs1_b_arch),
      .rs2_b_arch (rs2_b_arch),
      .rd_a_phy   (rd_a_phy),
      .rs1_a_phy  (rs1_a_phy),
      .rs2_a_phy  (rs2_a_phy),
      .rd_b_phy   (rd_b_phy),
      .rs1_b_phy  (rs1_b_phy),
      .rs2_b_phy  (rs2_b_phy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
      opcode_a = op; rd_a_arch = rd; rs1_a_arch = s1; rs2_a_arch = s2;
   endtask

   task automatic set_b(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
      opcode_b = op; rd_b_arch = rd; rs1_b_arch = s1; rs2_b_arch = s2;
   endtask

   // Commit the current inputs on the next rising edge, then settle.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      wr_ops[0] = c_OP;    wr_ops[1] = c_OPIMM; wr_ops[2] = c_LOAD; wr_ops[3] = c_LUI;
      wr_ops[4] = c_AUIPC; wr_ops[5] = c_JAL;   wr_ops[6] = c_JALR;

      reset = 1'b1;
      set_a(7'd0, 5'd0, 5'd0, 5'd0);
      set_b(7'd0, 5'd0, 5'd0, 5'd0);
      tick; tick;

      // Reset-state lookups are identity while reset is held.
      set_a(c_OP, 5'd4, 5'd5, 5'd31);
      set_b(c_STORE, 5'd9, 5'd0, 5'd17);
      #1;
      chk("rst_rs1_a", rs1_a_phy, 6'd5);
      chk("rst_rs2_a", rs2_a_phy, 6'd31);
      chk("rst_rs2_b", rs2_b_phy, 6'd17);
      chk("rst_rd_a", rd_a_phy, 6'd32);
      chk("rst_rd_b", rd_b_phy, 6'd0);
      tick;
      chk("rst_no_alloc", rd_a_phy, 6'd32);

      // Dual OP with intra-bundle bypass.
      reset = 1'b0;
      set_a(c_OP, 5'd1, 5'd2, 5'd3);
      set_b(c_OP, 5'd2, 5'd1, 5'd1);
      #1;
      chk("t1_rd_a", rd_a_phy, 6'd32);
      chk("t1_rs1_a", rs1_a_phy, 6'd2);
      chk("t1_rs2_a", rs2_a_phy, 6'd3);
      chk("t1_rd_b", rd_b_phy, 6'd33);
      chk("t1_rs1_b", rs1_b_phy, 6'd32);
      chk("t1_rs2_b", rs2_b_phy, 6'd32);
      tick;
      chk("t2_rs1_a", rs1_a_phy, 6'd33);
      chk("t2_rs2_a", rs2_a_phy, 6'd3);
      chk("t2_rd_a", rd_a_phy, 6'd34);
      chk("t2_rd_b", rd_b_phy, 6'd35);
      chk("t2_rs1_b", rs1_b_phy, 6'd34);
      chk("t2_rs2_b", rs2_b_phy, 6'd34);
      tick;

      // Non-writing A: no allocation, no bypass.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      set_a(c_STORE, 5'd5, 5'd0, 5'd0);
      set_b(c_OP, 5'd6, 5'd5, 5'd0);
      #1;
      chk("t3_rd_a", rd_a_phy, 6'd0);
      chk("t3_rd_b", rd_b_phy, 6'd32);
      chk("t3_rs1_b", rs1_b_phy, 6'd5);
      chk("t3_rs2_b", rs2_b_phy, 6'd0);
      tick;
      set_a(c_OP, 5'd8, 5'd6, 5'd0);
      set_b(7'd0, 5'd9, 5'd0, 5'd0);
      #1;
      chk("t3_next_ptr", rd_a_phy, 6'd33);
      chk("t3_rs1_a", rs1_a_phy, 6'd32);
      chk("t3_unknown_rd_b", rd_b_phy, 6'd0);
      tick;

      // rd = x0 allocates nothing; x0 reads p0.
      set_a(c_OP, 5'd0, 5'd0, 5'd8);
      set_b(c_OP, 5'd0, 5'd0, 5'd6);
      #1;
      chk("t4_rd_a", rd_a_phy, 6'd0);
      chk("t4_rd_b", rd_b_phy, 6'd0);
      chk("t4_rs1_a", rs1_a_phy, 6'd0);
      chk("t4_rs2_a", rs2_a_phy, 6'd33);
      chk("t4_rs1_b", rs1_b_phy, 6'd0);
      chk("t4_rs2_b", rs2_b_phy, 6'd32);
      tick;
      set_a(c_OP, 5'd10, 5'd0, 5'd0);
      set_b(c_LUI, 5'd11, 5'd10, 5'd0);
      #1;
      chk("t4_no_adv", rd_a_phy, 6'd34);
      chk("t4_lui_rd_b", rd_b_phy, 6'd35);
      chk("t4_bypass", rs1_b_phy, 6'd34);
      tick;

      // Same destination in both slots: B wins.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      set_a(c_OP, 5'd7, 5'd7, 5'd0);
      set_b(c_OP, 5'd7, 5'd7, 5'd0);
      #1;
      chk("t5_rd_a", rd_a_phy, 6'd32);
      chk("t5_rd_b", rd_b_phy, 6'd33);
      chk("t5_rs1_a", rs1_a_phy, 6'd7);
      chk("t5_rs1_b", rs1_b_phy, 6'd32);
      tick;
      set_a(c_STORE, 5'd7, 5'd7, 5'd0);
      set_b(c_BRANCH, 5'd7, 5'd0, 5'd7);
      #1;
      chk("t5_b_wins", rs1_a_phy, 6'd33);
      chk("t5_rs2_b", rs2_b_phy, 6'd33);
      chk("t5_branch_rd", rd_b_phy, 6'd0);
      tick;

      // Fill the pool to p62 using every writing opcode, then wrap.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         set_a(wr_ops[i % 7], 5'd1, 5'd0, 5'd0);
         set_b(wr_ops[(i + 3) % 7], 5'd2, 5'd0, 5'd0);
         #1;
         chk("fill_rd_a", rd_a_phy, 6'(32 + 2 * i));
         chk("fill_rd_b", rd_b_phy, 6'(33 + 2 * i));
         tick;
      end
      set_a(c_OP, 5'd3, 5'd1, 5'd2);
      set_b(c_SYSTEM, 5'd4, 5'd0, 5'd0);
      #1;
      chk("fill_single", rd_a_phy, 6'd62);
      chk("fill_sys_rd_b", rd_b_phy, 6'd0);
      chk("fill_rs1_a", rs1_a_phy, 6'd60);
      chk("fill_rs2_a", rs2_a_phy, 6'd61);
      tick;
      set_a(c_OP, 5'd5, 5'd0, 5'd0);
      set_b(c_OP, 5'd6, 5'd0, 5'd0);
      #1;
      chk("wrap_rd_a", rd_a_phy, 6'd63);
      chk("wrap_rd_b", rd_b_phy, 6'd32);
      tick;
      set_a(c_OP, 5'd9, 5'd5, 5'd6);
      set_b(c_OP, 5'd12, 5'd6, 5'd0);
      #1;
      chk("wrap_next", rd_a_phy, 6'd33);
      chk("wrap_rs1_a", rs1_a_phy, 6'd63);
      chk("wrap_rs2_a", rs2_a_phy, 6'd32);
      chk("wrap_rd_b2", rd_b_phy, 6'd34);

      // Mid-run reset restores identity and the pool base.
      reset = 1'b1;
      tick;
      chk("mid_rst_rs1_a", rs1_a_phy, 6'd5);
      chk("mid_rst_rs2_a", rs2_a_phy, 6'd6);
      chk("mid_rst_rd_a", rd_a_phy, 6'd32);
      tick;
      chk("mid_rst_hold", rd_b_phy, 6'd33);
      reset = 1'b0;
      #1;
      chk("post_rst_rs1_b", rs1_b_phy, 6'd6);
      tick;
      chk("post_rst_alloc", rd_a_phy, 6'd34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
